// File: rtl/stage5_key_mix.sv
// Key-mixing stage: XORs each permuted block with a rotating key window and
// buffers results in a 2-deep FIFO. Optional parity sideband: STAGE5_PARITY_EN.
module stage5_key_mix (
   input  logic         clk,
   input  logic         reset,
   input  logic         Enable,
   input  logic [7:0]   w0,
   input  logic [7:0]   w1,
   input  logic [7:0]   w2,
   input  logic [7:0]   w3,
   input  logic [7:0]   x0,
   input  logic [7:0]   x1,
   input  logic [7:0]   x2,
   input  logic [7:0]   x3,
   input  logic [7:0]   y0,
   input  logic [7:0]   y1,
   input  logic [7:0]   y2,
   input  logic [7:0]   y3,
   input  logic [7:0]   z0,
   input  logic [7:0]   z1,
   input  logic [7:0]   z2,
   input  logic [7:0]   z3,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic         key_load,
   output logic [7:0]   o0,
   output logic [7:0]   o1,
   output logic [7:0]   o2,
   output logic [7:0]   o3,
   output logic [7:0]   o4,
   output logic [7:0]   o5,
   output logic [7:0]   o6,
   output logic [7:0]   o7,
   output logic [7:0]   o8,
   output logic [7:0]   o9,
   output logic [7:0]   o10,
   output logic [7:0]   o11,
   output logic [7:0]   o12,
   output logic [7:0]   o13,
   output logic [7:0]   o14,
   output logic [7:0]   o15,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   round,
   output logic         round_wrap
`ifdef STAGE5_PARITY_EN
   ,
   output logic [15:0]  o_par
`endif
);

   logic [127:0] in_blk;
   logic [127:0] mix;
   logic [3:0]   idx;
   logic [127:0] key_q, key_d;
   logic [127:0] s0_q, s0_d;
   logic [127:0] s1_q, s1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         wrap_q, wrap_d;
   logic         push, pop;

   assign in_blk = {z3, z2, z1, z0, y3, y2, y1, y0,
                    x3, x2, x1, x0, w3, w2, w1, w0};

   assign in_ready   = Enable & (cnt_q != 2'd2);
   assign out_valid  = (cnt_q != 2'd0);
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready & Enable;
   assign round      = rnd_q;
   assign round_wrap = wrap_q & Enable;

   // Byte b picks key byte (b + round) mod 16; idx wraps naturally at 4 bits
   always_comb begin
      mix = '0;
      idx = '0;
      for (int b = 0; b < 16; b++) begin
         idx = 4'(b) + rnd_q;
         mix[8*b +: 8] = in_blk[8*b +: 8] ^ key_q[8*idx +: 8];
      end
   end

   always_comb begin
      s0_d   = s0_q;
      s1_d   = s1_q;
      cnt_d  = cnt_q;
      key_d  = key_q;
      rnd_d  = rnd_q;
      wrap_d = 1'b0;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) s0_d = mix;
            else               s1_d = mix;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            s0_d  = s1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               s0_d = mix;
            end else begin
               s0_d = s1_q;
               s1_d = mix;
            end
         end
         default: ;
      endcase
      // A key load restarts the sequence, so it does not count as a wrap
      if (Enable && key_load) begin
         key_d = key;
         rnd_d = 4'd0;
      end else if (push) begin
         rnd_d  = rnd_q + 4'd1;
         wrap_d = (rnd_q == 4'hF);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s0_q   <= '0;
         s1_q   <= '0;
         cnt_q  <= '0;
         key_q  <= '0;
         rnd_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         s0_q   <= s0_d;
         s1_q   <= s1_d;
         cnt_q  <= cnt_d;
         key_q  <= key_d;
         rnd_q  <= rnd_d;
         wrap_q <= wrap_d;
      end
   end

   assign {o15, o14, o13, o12, o11, o10, o9, o8,
           o7, o6, o5, o4, o3, o2, o1, o0} = s0_q;

`ifdef STAGE5_PARITY_EN
   logic [15:0] par_in;
   logic [15:0] p0_q, p0_d;
   logic [15:0] p1_q, p1_d;

   always_comb begin
      par_in = '0;
      for (int b = 0; b < 16; b++) begin
         par_in[b] = ^mix[8*b +: 8];
      end
   end

   always_comb begin
      p0_d = p0_q;
      p1_d = p1_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) p0_d = par_in;
            else               p1_d = par_in;
         end
         2'b01: p0_d = p1_q;
         2'b11: begin
            if (cnt_q == 2'd1) begin
               p0_d = par_in;
            end else begin
               p0_d = p1_q;
               p1_d = par_in;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         p0_q <= '0;
         p1_q <= '0;
      end else begin
         p0_q <= p0_d;
         p1_q <= p1_d;
      end
   end

   assign o_par = p0_q;
`endif

endmodule

// File: tb/tb_stage5_key_mix.sv
// Bench for stage5_key_mix: queue-based reference model with a per-cycle
// compare process, directed scenarios with literal expectations, random phase.
module tb_stage5_key_mix;

   logic         clk = 1'b0;
   logic         reset, Enable, in_valid, key_load, out_ready;
   logic [127:0] din, key;
   wire  [127:0] dout;
   wire          in_ready, out_valid, round_wrap;
   wire  [3:0]   round_o;
`ifdef STAGE5_PARITY_EN
   wire  [15:0]  o_par;
`endif

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   logic [127:0] mq[$];
   logic [127:0] mkey = '0;
   int           mround = 0;
   bit           mwrap = 1'b0;

   localparam logic [127:0] K1 = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] K2 = 128'hFFEEDDCCBBAA99887766554433221100;

   always #5 clk = ~clk;

   stage5_key_mix dut (
      .clk(clk), .reset(reset), .Enable(Enable),
      .w0(din[7:0]),     .w1(din[15:8]),
      .w2(din[23:16]),   .w3(din[31:24]),
      .x0(din[39:32]),   .x1(din[47:40]),
      .x2(din[55:48]),   .x3(din[63:56]),
      .y0(din[71:64]),   .y1(din[79:72]),
      .y2(din[87:80]),   .y3(din[95:88]),
      .z0(din[103:96]),  .z1(din[111:104]),
      .z2(din[119:112]), .z3(din[127:120]),
      .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .key_load(key_load),
      .o0(dout[7:0]),     .o1(dout[15:8]),
      .o2(dout[23:16]),   .o3(dout[31:24]),
      .o4(dout[39:32]),   .o5(dout[47:40]),
      .o6(dout[55:48]),   .o7(dout[63:56]),
      .o8(dout[71:64]),   .o9(dout[79:72]),
      .o10(dout[87:80]),  .o11(dout[95:88]),
      .o12(dout[103:96]), .o13(dout[111:104]),
      .o14(dout[119:112]), .o15(dout[127:120]),
      .out_valid(out_valid), .out_ready(out_ready),
      .round(round_o), .round_wrap(round_wrap)
`ifdef STAGE5_PARITY_EN
      , .o_par(o_par)
`endif
   );

   function automatic logic [127:0] mixf(input logic [127:0] blk,
                                         input logic [127:0] k,
                                         input int r);
      logic [127:0] res;
      for (int b = 0; b < 16; b++)
         res[8*b +: 8] = blk[8*b +: 8] ^ k[8*((b + r) % 16) +: 8];
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a queue of mixed blocks plus key/round bookkeeping
   always @(posedge clk) begin
      bit psh, pp;
      logic [127:0] m;
      if (!reset) begin
         mq.delete();
         mkey   = '0;
         mround = 0;
         mwrap  = 1'b0;
      end else if (Enable) begin
         psh = in_valid && (mq.size() < 2);
         pp  = out_ready && (mq.size() > 0);
         m   = mixf(din, mkey, mround);
         if (pp) void'(mq.pop_front());
         if (psh) mq.push_back(m);
         mwrap = psh && (mround == 15) && !key_load;
         if (key_load) begin
            mkey   = key;
            mround = 0;
         end else if (psh) begin
            mround = (mround + 1) % 16;
         end
      end else begin
         mwrap = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("out_valid", out_valid, mq.size() != 0);
         chk("in_ready", in_ready, Enable && (mq.size() < 2));
         chk("round", round_o, mround);
         chk("round_wrap", round_wrap, mwrap && Enable);
         if (mq.size() != 0) chk("data", dout, mq[0]);
      end
   end

   initial begin
      logic [127:0] snap;
      logic [3:0]   rsnap;
      reset = 1'b0; Enable = 1'b1; in_valid = 1'b0;
      key_load = 1'b0; out_ready = 1'b0; din = '0; key = '0;
      step(); step();
      chk("rst_valid", out_valid, 0);
      chk("rst_data", dout, 0);
      chk("rst_round", round_o, 0);
      chk("rst_wrap", round_wrap, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 1'b1;
      cmp_en = 1'b1;

      // all-0xFF block against key byte j = j at round 0
      key = K1; key_load = 1'b1;
      step();
      key_load = 1'b0;
      chk("kl_round", round_o, 0);
      din = '1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("ff_valid", out_valid, 1);
      chk("ff_data", dout, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
      chk("ff_round", round_o, 1);
      step();
      chk("drain_valid", out_valid, 0);

      // backpressure: three offered, two accepted
      out_ready = 1'b0; in_valid = 1'b1; din = '0;
      step();
      step();
      din = 128'h12345678;
      chk("bp_in_ready", in_ready, 0);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      chk("bp_head_a", dout, 128'h000F0E0D0C0B0A090807060504030201);
      step();
      chk("bp_head_b", dout, 128'h01000F0E0D0C0B0A0908070605040302);
      chk("bp_ready_back", in_ready, 1);
      step();
      chk("bp_empty", out_valid, 0);

      // Enable low freezes everything
      din = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1; out_ready = 1'b0;
      step();
      snap = dout; rsnap = round_o;
      Enable = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_in_ready", in_ready, 0);
         chk("hold_data", dout, snap);
         chk("hold_valid", out_valid, 1);
         chk("hold_round", round_o, rsnap);
      end
      Enable = 1'b1; in_valid = 1'b0;
      step();

      // key_load with a push at round 5
      din = '0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("r5_round", round_o, 5);
      key = K2; key_load = 1'b1; in_valid = 1'b1;
      step();
      key_load = 1'b0;
      chk("kl5_round", round_o, 0);
      chk("kl5_data", dout, 128'h04030201000F0E0D0C0B0A0908070605);
      step();
      in_valid = 1'b0;
      chk("newkey_data", dout, K2);
      chk("newkey_round", round_o, 1);
      step();

      // 16 pushes: exactly one wrap pulse after the 16th
      key = K1; key_load = 1'b1;
      step();
      key_load = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         step();
         chk("wrap_pulse", round_wrap, i == 15);
         chk("wrap_round", round_o, (i + 1) % 16);
      end
      in_valid = 1'b0;
      step();
      chk("wrap_clear", round_wrap, 0);

      // reset while full
      in_valid = 1'b1; out_ready = 1'b0;
      step(); step();
      in_valid = 1'b0;
      chk("full_in_ready", in_ready, 0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_data", dout, 0);
      chk("mrst_round", round_o, 0);
      chk("mrst_in_ready", in_ready, 1);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 99) != 0);
         Enable    = ($urandom_range(0, 99) < 85);
         key_load  = ($urandom_range(0, 29) == 0);
         key       = {$urandom, $urandom, $urandom, $urandom};
         din       = {$urandom, $urandom, $urandom, $urandom};
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 50);
         step();
      end
      reset = 1'b1; Enable = 1'b1; in_valid = 1'b0; key_load = 1'b0;
      step();
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stage5_key_mix.md
STAGE5_KEY_MIX -- requirements
Module: stage5_key_mix

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port Enable, input, 1 bit: stage advance enable; low means hold all state.
REQ-004 SHALL have ports w0..w3, x0..x3, y0..y3, z0..z3, input, 8 bits each: permuted block from the preceding permutation stage; byte index b = 4*word + n, with w=0, x=1, y=2, z=3.
REQ-005 SHALL have port in_valid, input, 1 bit: input block present.
REQ-006 SHALL have port in_ready, output, 1 bit: stage can accept a block.
REQ-007 SHALL have port key, input, 128 bits: cipher key; byte j = key[8j+7:8j].
REQ-008 SHALL have port key_load, input, 1 bit: capture key and restart the round sequence.
REQ-009 SHALL have ports o0..o15, output, 8 bits each: mixed block bytes.
REQ-010 SHALL have port out_valid, output, 1 bit: output block present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the block.
REQ-012 SHALL have port round, output, 4 bits: round index for the next accepted block.
REQ-013 SHALL have port round_wrap, output, 1 bit: one-cycle pulse when round wraps from 15 to 0.

Function
REQ-014 SHALL hold a 2-entry FIFO of mixed blocks; count is 0..2.
REQ-015 SHALL drive in_ready = Enable AND (count != 2), combinationally from registers.
REQ-016 SHALL accept a block (push) when in_valid, in_ready and Enable are all high.
REQ-017 SHALL compute each pushed byte as in[b] XOR keyreg[(b + round) mod 16], using the key register and round value current in the push cycle.
REQ-018 SHALL drive out_valid = (count != 0), with o0..o15 taken from the FIFO head.
REQ-019 SHALL pop the head when out_valid, out_ready and Enable are all high.
REQ-020 SHALL, on a simultaneous push and pop, leave count unchanged and preserve block order.
REQ-021 SHALL give 1-cycle latency: a block pushed into an empty FIFO appears on o0..o15 with out_valid in the next cycle.
REQ-022 SHALL hold o0..o15 stable while out_valid is high and out_ready is low.
REQ-023 SHALL increment round modulo 16 on each push; the push at round=15 sets round to 0 and pulses round_wrap high for the next cycle.
REQ-024 SHALL, on key_load with Enable high, load the key register from key and clear round to 0; key_load takes priority over the push increment, and a same-cycle push uses the old key and old round.
REQ-025 SHALL ignore key_load while Enable is low.
REQ-026 SHALL freeze the FIFO, round, the key register and all outputs while Enable is low, except that round_wrap SHALL be driven low.

Reset
REQ-027 SHALL, when reset is low at a clock edge, set count=0, out_valid=0, o0..o15=0x00, round=0, round_wrap=0 and the key register to 0; reset overrides Enable and key_load.
REQ-028 SHALL discard buffered blocks when reset is asserted mid-operation, with no output beat produced.

Configuration
REQ-029 SHALL, with macro STAGE5_PARITY_EN defined, add output port o_par[15:0], where bit b is the odd parity of output byte b, carried through the FIFO alongside the data.
REQ-030 SHALL, without STAGE5_PARITY_EN, omit o_par and its storage; all other behaviour is identical.

Verification
REQ-031 SHALL test: key=0x0F0E..0100 (byte j = j) loaded, round=0, all input bytes 0xFF, out_ready=1 -> next cycle out_valid=1 and o_b = 0xFF XOR b (o0=0xFF, o15=0xF0), round=1.
REQ-032 SHALL test: out_ready=0 with 3 blocks offered back-to-back -> 2 accepted, in_ready=0 on the third cycle; then out_ready=1 -> blocks emerge in order, then in_ready returns to 1.
REQ-033 SHALL test: 16 consecutive pushes after key_load -> round_wrap pulses exactly once, in the cycle after the 16th push, with round=0.
REQ-034 SHALL test: key_load together with a push at round=5 -> the pushed block is mixed with the old key at round 5, then round=0 and the new key is in effect.
REQ-035 SHALL test: Enable=0 for 3 cycles with in_valid=1 and out_ready=1 -> no push, no pop, outputs unchanged, in_ready=0.
REQ-036 SHALL test: reset low while count=2 -> the next cycle shows out_valid=0, o*=0x00, round=0 and in_ready=1 once reset is high and Enable is high.
